// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and types for the UART transmit FIFO.
package uart_tx_fifo_pkg;

   localparam logic [31:0] TX_CSR_ADDR = 32'd2;

   typedef logic [31:0] tx_word_t;

   function automatic int unsigned lvl_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_param_status.sv
// Registered occupancy level and full/empty/almost-full flags, all derived from the next level.
module uart_fifo_status
   import uart_tx_fifo_pkg::*;
#(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AF_THRESH = 12,
   localparam int unsigned LW       = lvl_w(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic [LW-1:0] i_level_next,
   output logic [LW-1:0] o_level,
   output logic          o_full,
   output logic          o_empty,
   output logic          o_almost_full
);

   logic [LW-1:0] r_level;
   logic          r_full;
   logic          r_empty;
   logic          r_almost_full;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_level       <= '0;
         r_full        <= 1'b0;
         r_empty       <= 1'b1;
         r_almost_full <= 1'b0;
      end else begin
         r_level       <= i_level_next;
         r_full        <= (i_level_next == LW'(DEPTH));
         r_empty       <= (i_level_next == '0);
         r_almost_full <= (i_level_next >= LW'(AF_THRESH));
      end
   end

   assign o_level       = r_level;
   assign o_full        = r_full;
   assign o_empty       = r_empty;
   assign o_almost_full = r_almost_full;

endmodule

// File: rtl/uart_tx_fifo_param.sv
// First-word-fall-through TX FIFO fed by CSR writes to the TX data register.
// Optional sticky overflow/underflow flags are enabled by defining UART_TX_FIFO_ERR_EN.
module uart_tx_fifo_param
   import uart_tx_fifo_pkg::*;
#(
   parameter int unsigned            DATA_W    = 32,
   parameter int unsigned            DEPTH     = 16,
   parameter int unsigned            ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]      TX_ADDR   = ADDR_W'(TX_CSR_ADDR),
   parameter int unsigned            AF_THRESH = 12,
   localparam int unsigned           LW        = lvl_w(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_csr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_ready,
   output logic              o_rd_valid,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_almost_full,
   output logic [LW-1:0]     o_level,
   output logic              o_overflow,
   output logic              o_underflow,
   input  logic              i_err_clr
);

   localparam int unsigned PW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo_param: DEPTH must be a power of two >= 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("uart_tx_fifo_param: AF_THRESH must be in 1..DEPTH");
   end

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [LW-1:0]     w_level;
   logic [LW-1:0]     w_level_next;
   logic              w_full;
   logic              w_empty;
   logic              w_almost_full;
   logic              w_addr_hit;
   logic              w_push;
   logic              w_pop;

   assign w_addr_hit = (i_csr_addr == TX_ADDR);
   assign w_push     = i_wr_en && w_addr_hit && !w_full;
   assign w_pop      = !w_empty && i_rd_ready;

   always_comb begin
      w_level_next = w_level;
      if (w_push && !w_pop) begin
         w_level_next = w_level + LW'(1);
      end else if (w_pop && !w_push) begin
         w_level_next = w_level - LW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
      end
   end

   // Storage has no reset; only pointers and level define validity.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= i_wr_data;
   end

   uart_fifo_status #(
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH)
   ) u_status (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_level_next  (w_level_next),
      .o_level       (w_level),
      .o_full        (w_full),
      .o_empty       (w_empty),
      .o_almost_full (w_almost_full)
   );

`ifdef UART_TX_FIFO_ERR_EN
   logic r_overflow;
   logic r_underflow;

   // A new error in the same cycle as err_clr wins, so the flag stays set.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (i_wr_en && w_addr_hit && w_full) r_overflow <= 1'b1;
         else if (i_err_clr)                  r_overflow <= 1'b0;
         if (i_rd_ready && w_empty)           r_underflow <= 1'b1;
         else if (i_err_clr)                  r_underflow <= 1'b0;
      end
   end

   assign o_overflow  = r_overflow;
   assign o_underflow = r_underflow;
`else
   logic w_unused;
   assign w_unused    = i_err_clr;
   assign o_overflow  = 1'b0;
   assign o_underflow = 1'b0;
`endif

   assign o_rd_valid    = !w_empty;
   assign o_rd_data     = w_empty ? '0 : r_mem[r_rptr];
   assign o_full        = w_full;
   assign o_empty       = w_empty;
   assign o_almost_full = w_almost_full;
   assign o_level       = w_level;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Scoreboard bench for uart_tx_fifo_param: queue-based reference model plus a pop monitor.
module tb_uart_tx_fifo_param;
   import uart_tx_fifo_pkg::*;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AF    = 12;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [31:0] csr_addr;
   logic [31:0] wr_data;
   logic        rd_ready;
   logic        err_clr;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        full;
   logic        empty;
   logic        almost_full;
   logic [4:0]  level;
   logic        overflow;
   logic        underflow;

   int          total = 0;
   int          bad   = 0;
   tx_word_t    sb[$];
   int          mlevel = 0;
   bit          mov = 0;
   bit          mun = 0;

   uart_tx_fifo_param #(
      .DATA_W    (32),
      .DEPTH     (DEPTH),
      .ADDR_W    (32),
      .TX_ADDR   (32'd2),
      .AF_THRESH (AF)
   ) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_wr_en       (wr_en),
      .i_csr_addr    (csr_addr),
      .i_wr_data     (wr_data),
      .i_rd_ready    (rd_ready),
      .o_rd_valid    (rd_valid),
      .o_rd_data     (rd_data),
      .o_full        (full),
      .o_empty       (empty),
      .o_almost_full (almost_full),
      .o_level       (level),
      .o_overflow    (overflow),
      .o_underflow   (underflow),
      .i_err_clr     (err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: a handshake seen before the edge retires the oldest expected word.
   always @(negedge clk) begin
      if (!reset && rd_valid && rd_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pop: got 0x%0h expected no valid entry", rd_data);
         end else begin
            chk("rd_data", rd_data, sb.pop_front());
         end
      end
   end

   task automatic step(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input bit rdy, input bit clr, input bit rst);
      bit hit;
      bit push;
      bit pop;
      reset    = rst;
      wr_en    = wr;
      csr_addr = addr;
      wr_data  = data;
      rd_ready = rdy;
      err_clr  = clr;
      hit      = wr && (addr == 32'd2);
      if (rst) begin
         sb.delete();
         mlevel = 0;
         mov    = 0;
         mun    = 0;
      end else begin
         pop  = (mlevel > 0) && rdy;
         push = hit && (mlevel < DEPTH);
         if (push) sb.push_back(data);
`ifdef UART_TX_FIFO_ERR_EN
         if (hit && mlevel == DEPTH) mov = 1;
         else if (clr)               mov = 0;
         if (rdy && mlevel == 0)     mun = 1;
         else if (clr)               mun = 0;
`endif
         mlevel = mlevel + int'(push) - int'(pop);
      end
      @(posedge clk);
      #1;
      chk("level", 32'(level), 32'(mlevel));
      chk("full", 32'(full), 32'(mlevel == DEPTH));
      chk("empty", 32'(empty), 32'(mlevel == 0));
      chk("almost_full", 32'(almost_full), 32'(mlevel >= AF));
      chk("rd_valid", 32'(rd_valid), 32'(mlevel != 0));
      chk("overflow", 32'(overflow), 32'(mov));
      chk("underflow", 32'(underflow), 32'(mun));
      if (mlevel == 0) chk("rd_data_empty", rd_data, 32'h0);
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; csr_addr = '0; wr_data = '0; rd_ready = 1'b0; err_clr = 1'b0;
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);

      // Fill 1..16, the 17th is dropped.
      for (int i = 1; i <= 17; i++) step(1, 2, 32'(i), 0, 0, 0);
      // Drain back-to-back, plus one ready on empty.
      for (int i = 0; i < 17; i++) step(0, 2, 0, 1, 0, 0);
      step(0, 2, 0, 0, 1, 0);

      // Wrong address never lands.
      step(1, 3, 32'hDEAD, 0, 0, 0);
      step(0, 2, 0, 0, 0, 0);

      // Full with simultaneous push and pop, then steady-state wrap.
      for (int i = 0; i < 16; i++) step(1, 2, 32'h100 + 32'(i), 0, 0, 0);
      step(1, 2, 32'hAA, 1, 0, 0);
      for (int i = 0; i < 20; i++) step(1, 2, $urandom, 1, 0, 0);

      // Overflow, underflow, then clear.
      step(1, 2, 32'h55, 0, 0, 0);
      step(1, 2, 32'h66, 0, 0, 0);
      step(1, 2, 32'h77, 0, 1, 0);
      step(1, 2, 32'h88, 0, 0, 0);
      for (int i = 0; i < 17; i++) step(0, 2, 0, 1, 0, 0);
      step(0, 2, 0, 0, 1, 0);

      // Reset mid-stream at level 7 with push and pop active.
      for (int i = 0; i < 7; i++) step(1, 2, $urandom, 0, 0, 0);
      step(1, 2, 32'h1234, 1, 0, 1);
      step(0, 2, 0, 0, 0, 0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) != 0, (($urandom % 5) == 0) ? 32'd3 : 32'd2, $urandom,
              ($urandom % 3) != 0, ($urandom % 16) == 0, ($urandom % 150) == 0);
      end
      for (int i = 0; i < 20; i++) step(0, 2, 0, 1, 0, 0);
      chk("scoreboard_left", 32'(sb.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
